// File: rtl/dfc_arbiter_if.sv
// Bundle between the DFC arbiter, its two client FSMs and the DFC datapath.
//
// Handshake semantics:
//   - req[i] is a level request that the client holds until gnt[i] pulses; dropping it
//     earlier withdraws it, and changes after gnt[i] are ignored until done[i].
//   - gnt[i], rsp_valid[i] and done[i] are single-cycle strobes, one-hot or zero.
//   - pld_rdy[i] means "the byte on pld_data[i] is consumed this cycle"; there is no
//     back-pressure from the client, it must present a valid byte whenever pld_rdy[i] is high.
//   - dfc_cmd_valid is a one-cycle command strobe; the DFC stalls the arbiter with dfc_busy.
//   - dfc_output_valid is a one-cycle result strobe with no back-pressure.
// fsm_state exposes the arbiter FSM state for observation.
interface dfc_arbiter_if;
    logic [1:0]  req;
    logic [3:0]  req_cmd;
    logic [7:0]  req_len;
    logic [1:0]  gnt;
    logic [1:0]  pld_rdy;
    logic [15:0] pld_data;
    logic [1:0]  rsp_valid;
    logic [8:0]  rsp_data;
    logic [1:0]  done;
    logic        done_err;
    logic        stray;
    logic [1:0]  dfc_cmd;
    logic        dfc_cmd_valid;
    logic [7:0]  dfc_datain;
    logic        dfc_busy;
    logic        dfc_output_valid;
    logic [8:0]  dfc_dataout;
    logic [2:0]  fsm_state;

    modport master (
        input  req, req_cmd, req_len, pld_data, dfc_busy, dfc_output_valid, dfc_dataout,
        output gnt, pld_rdy, rsp_valid, rsp_data, done, done_err, stray,
               dfc_cmd, dfc_cmd_valid, dfc_datain, fsm_state
    );

    modport slave (
        output req, req_cmd, req_len, pld_data, dfc_busy, dfc_output_valid, dfc_dataout,
        input  gnt, pld_rdy, rsp_valid, rsp_data, done, done_err, stray,
               dfc_cmd, dfc_cmd_valid, dfc_datain, fsm_state
    );
endinterface

// File: rtl/dfc_arbiter.sv
// Round-robin arbiter sharing one DFC datapath between two requesters.
// One transaction at a time: IDLE -> ISSUE -> (LOAD) -> WAIT -> DONE -> IDLE.
module dfc_arbiter #(
    parameter int LOAD_LEN = 8,
    parameter int TIMEOUT  = 1000
) (
    input  logic         clk,
    input  logic         reset,
    dfc_arbiter_if.master bus
);

    localparam int LCW = (LOAD_LEN > 1) ? $clog2(LOAD_LEN) : 1;
    localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_LOAD  = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t         state;
    logic           g;          // requester owning the current transaction
    logic           last;       // requester served most recently
    logic [1:0]     cmd_q;
    logic [3:0]     len_q;
    logic [3:0]     beat_cnt;
    logic           err;
    logic [LCW-1:0] load_cnt;
    logic [TCW-1:0] tmo_cnt;

    logic           sel_g;
    logic [1:0]     g_onehot;
    logic           timeout_hit;
    logic           wait_exit;

    // Round-robin pick: with both requesting, take the one not served last.
    always_comb begin
        sel_g = bus.req[1];
        if (bus.req == 2'b11) begin
            sel_g = ~last;
        end
    end

    assign g_onehot    = g ? 2'b10 : 2'b01;
    // tmo_cnt saturates at TIMEOUT-1, so the timeout stays asserted until WAIT is left.
    assign timeout_hit = (tmo_cnt == TCW'(TIMEOUT - 1));
    // A beat arriving this cycle holds off the exit so done always trails the last rsp_valid.
    assign wait_exit   = !bus.dfc_output_valid &&
                         (((beat_cnt == len_q) && !bus.dfc_busy) || timeout_hit);
    assign bus.fsm_state = state;

    // Payload passes straight from the granted requester to the DFC during LOAD only.
    always_comb begin
        bus.dfc_datain = 8'h00;
        if (state == S_LOAD) begin
            bus.dfc_datain = g ? bus.pld_data[15:8] : bus.pld_data[7:0];
        end
    end

    // Arbiter FSM with registered strobes and result path.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= S_IDLE;
            g                 <= 1'b0;
            last              <= 1'b1;
            cmd_q             <= 2'b00;
            len_q             <= 4'h0;
            beat_cnt          <= 4'h0;
            err               <= 1'b0;
            load_cnt          <= '0;
            tmo_cnt           <= '0;
            bus.gnt           <= 2'b00;
            bus.pld_rdy       <= 2'b00;
            bus.rsp_valid     <= 2'b00;
            bus.rsp_data      <= 9'h000;
            bus.done          <= 2'b00;
            bus.done_err      <= 1'b0;
            bus.stray         <= 1'b0;
            bus.dfc_cmd       <= 2'b00;
            bus.dfc_cmd_valid <= 1'b0;
        end else begin
            bus.gnt           <= 2'b00;
            bus.done          <= 2'b00;
            bus.done_err      <= 1'b0;
            bus.dfc_cmd       <= 2'b00;
            bus.dfc_cmd_valid <= 1'b0;
            bus.rsp_valid     <= 2'b00;

            // Result beats outside WAIT have no owner: drop them and flag it.
            if (bus.dfc_output_valid && (state != S_WAIT)) begin
                bus.stray <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if ((|bus.req) && !bus.dfc_busy) begin
                        g                 <= sel_g;
                        cmd_q             <= sel_g ? bus.req_cmd[3:2] : bus.req_cmd[1:0];
                        len_q             <= sel_g ? bus.req_len[7:4] : bus.req_len[3:0];
                        bus.gnt           <= sel_g ? 2'b10 : 2'b01;
                        bus.dfc_cmd       <= sel_g ? bus.req_cmd[3:2] : bus.req_cmd[1:0];
                        bus.dfc_cmd_valid <= 1'b1;
                        state             <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (cmd_q == 2'b00) begin
                        bus.pld_rdy <= g_onehot;
                        load_cnt    <= '0;
                        state       <= S_LOAD;
                    end else begin
                        state <= S_WAIT;
                    end
                end
                S_LOAD: begin
                    if (load_cnt == LCW'(LOAD_LEN - 1)) begin
                        bus.pld_rdy <= 2'b00;
                        state       <= S_WAIT;
                    end else begin
                        load_cnt <= load_cnt + LCW'(1);
                    end
                end
                S_WAIT: begin
                    if (bus.dfc_output_valid) begin
                        bus.rsp_data  <= bus.dfc_dataout;
                        bus.rsp_valid <= g_onehot;
                        if (beat_cnt == len_q) begin
                            err <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 4'd1;
                        end
                    end
                    if (!timeout_hit) begin
                        tmo_cnt <= tmo_cnt + TCW'(1);
                    end
                    if (wait_exit) begin
                        bus.done     <= g_onehot;
                        bus.done_err <= err | timeout_hit;
                        state        <= S_DONE;
                    end
                end
                S_DONE: begin
                    last     <= g;
                    beat_cnt <= 4'h0;
                    tmo_cnt  <= '0;
                    err      <= 1'b0;
                    state    <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
